// File: rtl/afifo_pkg.sv
// Shared async-FIFO helpers, used by both the write-side and read-side
// pointer controllers.
//   ptr_w(aw)       : pointer width for a given address width (aw+1; the
//                     extra MSB tells full apart from empty)
//   bin2gray(b)     : binary -> reflected Gray
//   gray2bin(g, w)  : Gray -> binary over the low w bits of g
// Both conversions work on a wide container type; callers zero-extend
// into ptr_t and truncate the result back to their own pointer width.
package afifo_pkg;

  localparam int MAX_PTR_W = 32;
  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the XOR of Gray bits i..w-1. Bits at or
  // above w are masked first so stray upper bits cannot leak in.
  function automatic ptr_t gray2bin(input ptr_t g, input int w);
    ptr_t gm;
    ptr_t b;
    gm = g & ((ptr_t'(1) << w) - ptr_t'(1));
    b  = '0;
    for (int i = 0; i < MAX_PTR_W; i++)
      b[i] = ^(gm >> i);
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO control bundle.
//   master : the write client plus the read->write synchronizer output
//            (drives w_en, rptr_sync, ovf_clr)
//   slave  : wptr_full_ctrl (drives address, Gray pointer and flags)
interface wptr_full_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic                  w_en;
  logic [PTR_W-1:0]      rptr_sync;
  logic                  ovf_clr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PTR_W-1:0]      wptr;
  logic                  wr_ack;
  logic                  full;
  logic                  almost_full;
  logic [PTR_W-1:0]      wcount;
  logic                  overflow;

  modport master (
    output w_en, rptr_sync, ovf_clr,
    input  waddr, wptr, wr_ack, full, almost_full, wcount, overflow
  );

  modport slave (
    input  w_en, rptr_sync, ovf_clr,
    output waddr, wptr, wr_ack, full, almost_full, wcount, overflow
  );

endinterface

// File: rtl/wptr_full_ctrl_gray2bin_dec.sv
// gray2bin_dec: combinational Gray -> binary decoder.
//   gray : W-bit Gray code in
//   bin  : W-bit binary out
// Used on the synchronized read pointer here; the read-side controller
// instantiates the same block on the synchronized write pointer.
module gray2bin_dec
  import afifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(ptr_t'(gray), W));

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer and full-flag controller for the
// asynchronous FIFO.
//   clk, rst_n       : write clock, async active-low reset
//   bus.w_en         : write request (accepted only when not full)
//   bus.rptr_sync    : Gray read pointer, already synchronized into clk
//   bus.ovf_clr      : clears the sticky overflow flag
//   bus.waddr        : memory write address (binary pointer LSBs)
//   bus.wptr         : registered Gray write pointer to the read side
//   bus.wr_ack       : a write was accepted on the previous edge
//   bus.full         : registered full flag
//   bus.almost_full  : registered, fill >= AFULL_THRESH
//   bus.wcount       : registered fill level 0..2^ADDR_WIDTH
//   bus.overflow     : sticky, a write was attempted while full
// Flags are pessimistic: rptr_sync lags the real read pointer, so full
// may linger after space frees up but never drops while truly full.
module wptr_full_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  wptr_full_ctrl_if.slave   bus
);

  localparam int PTR_W = ptr_w(ADDR_WIDTH);

  // Full when the write pointer equals the read pointer with its top two
  // Gray bits inverted: one full lap ahead in Gray space.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
  localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] b_wptr;
  logic [PTR_W-1:0] wptr_q;
  logic             full_q;
  logic             afull_q;
  logic [PTR_W-1:0] cnt_q;
  logic             ack_q;
  logic             ovf_q;

  logic             accept;
  logic [PTR_W-1:0] b_next;
  logic [PTR_W-1:0] g_next;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] cnt_next;
  logic             full_next;

  gray2bin_dec #(.W(PTR_W)) u_rdec (
    .gray (bus.rptr_sync),
    .bin  (rbin)
  );

  assign accept    = bus.w_en & ~full_q;
  assign b_next    = b_wptr + {{(PTR_W-1){1'b0}}, accept};
  assign g_next    = PTR_W'(bin2gray(ptr_t'(b_next)));
  assign full_next = (g_next == (bus.rptr_sync ^ FULL_MASK));
  // Modular subtraction gives the fill level directly, lap bit included.
  assign cnt_next  = b_next - rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wptr  <= '0;
      wptr_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      b_wptr  <= b_next;
      wptr_q  <= g_next;
      full_q  <= full_next;
      afull_q <= (cnt_next >= AF_LVL);
      cnt_q   <= cnt_next;
      ack_q   <= accept;
      // set beats clear when both land in the same cycle
      if (bus.w_en & full_q)
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // wptr leaves straight from its flop: it crosses clock domains.
  assign bus.wptr        = wptr_q;
  assign bus.waddr       = b_wptr[ADDR_WIDTH-1:0];
  assign bus.wr_ack      = ack_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wcount      = cnt_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// The reference tracks total writes and total reads as plain integers;
// the expected outputs after each edge follow from their difference.
module tb_wptr_full_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AFT   = 6;

  typedef struct {
    int waddr;
    int wptr;
    int ack;
    int full;
    int af;
    int cnt;
    int ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  wptr_full_ctrl_if #(.ADDR_WIDTH(AW)) ifc ();

  wptr_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // reference state
  int wr_total = 0;
  int rd_total = 0;
  int m_full   = 0;
  int m_ovf    = 0;

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"},  32'(ifc.waddr), 0);
    chk({tag, "_wptr"},   32'(ifc.wptr), 0);
    chk({tag, "_ack"},    32'(ifc.wr_ack), 0);
    chk({tag, "_full"},   32'(ifc.full), 0);
    chk({tag, "_afull"},  32'(ifc.almost_full), 0);
    chk({tag, "_wcount"}, 32'(ifc.wcount), 0);
    chk({tag, "_ovf"},    32'(ifc.overflow), 0);
  endtask

  // One cycle of stimulus; the expected state after the coming edge is queued.
  task automatic step(input bit w, input bit adv, input bit clr);
    exp_t e;
    int   fill;
    bit   acc;
    @(negedge clk);
    if (adv && rd_total < wr_total) rd_total++;
    ifc.w_en      = w;
    ifc.ovf_clr   = clr;
    ifc.rptr_sync = (AW+1)'(gray(rd_total % (2*DEPTH)));
    acc = w && (m_full == 0);
    if (acc) wr_total++;
    fill   = wr_total - rd_total;
    m_ovf  = (w && m_full != 0) ? 1 : (clr ? 0 : m_ovf);
    m_full = (fill == DEPTH) ? 1 : 0;
    e.waddr = wr_total % DEPTH;
    e.wptr  = gray(wr_total % (2*DEPTH));
    e.ack   = acc ? 1 : 0;
    e.full  = m_full;
    e.af    = (fill >= AFT) ? 1 : 0;
    e.cnt   = fill;
    e.ovf   = m_ovf;
    q.push_back(e);
  endtask

  // monitor: compare one queued expectation per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("waddr",       32'(ifc.waddr),       e.waddr);
        chk("wptr",        32'(ifc.wptr),        e.wptr);
        chk("wr_ack",      32'(ifc.wr_ack),      e.ack);
        chk("full",        32'(ifc.full),        e.full);
        chk("almost_full", 32'(ifc.almost_full), e.af);
        chk("wcount",      32'(ifc.wcount),      e.cnt);
        chk("overflow",    32'(ifc.overflow),    e.ovf);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    ifc.w_en      = 1'b0;
    ifc.ovf_clr   = 1'b0;
    ifc.rptr_sync = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // fill from empty, rptr_sync held at 0
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    step(1, 0, 0);   // rejected, overflow rises
    step(0, 0, 0);   // overflow holds
    step(0, 0, 1);   // cleared
    step(1, 0, 1);   // rejected write with clear: set wins
    step(0, 0, 1);
    step(0, 1, 0);   // one read seen: full drops, wcount 7
    step(1, 0, 0);   // refill: full, wptr 13

    // drain, then 32 writes chased by reads
    while (rd_total < wr_total) step(0, 1, 0);
    for (int i = 0; i < 32; i++) step(1, 1, 0);
    while (rd_total < wr_total) step(0, 1, 0);

    // five writes, then async reset between edges
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    wr_total = 0; rd_total = 0; m_full = 0; m_ovf = 0;
    ifc.w_en = 1'b0; ifc.ovf_clr = 1'b0; ifc.rptr_sync = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 0, 0);   // first write after reset: wptr 1

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 8) == 0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
